prt_scaler_hbs_ctl: RTL and testbench

PRT_SCALER_HBS_CTL -- requirements
Module: prt_scaler_hbs_ctl

---
 rtl/prt_scaler_hbs_ctl_pkg.sv | 19 +
 rtl/prt_scaler_hbs_ctl.sv | 154 +++++++++++++++
 tb/tb_prt_scaler_hbs_ctl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prt_scaler_hbs_ctl_pkg.sv
// Shared types and constants for the scaler horizontal-block-sequencer control.
// Holds the control FSM state encoding and the length of the line-end drain phase.
package prt_scaler_hbs_ctl_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LSTART = 2'd1,
      ST_READ   = 2'd2,
      ST_LEND   = 2'd3
   } hbs_state_e;

   // Cycles spent in LEND so the final write's second half can drain
   localparam int unsigned LEND_CYCLES = 2;

   // Width of the completed-line status counter
   localparam int unsigned LINES_W = 16;

endpackage

// File: rtl/prt_scaler_hbs_ctl.sv
// Line FIFO to 2x-upsampling scaler feeder.
// Reads one word every other cycle from the line FIFO, forwards it to the scaler
// with a write strobe one cycle later, brackets each line with a line-start pulse
// and a two-cycle drain, and keeps underflow / completed-line status.
//
// Ports:
//   CLK_IN, RST_IN         clock, asynchronous active-low reset
//   CTL_RUN_IN             run enable (sampled only at line boundaries)
//   CFG_HWORDS_IN          words per line, latched at line start
//   FIFO_EP_IN/RD_OUT/DAT_IN  line FIFO empty / read strobe / data (1-cycle latency)
//   HBS_HS_OUT/DAT_OUT/WR_OUT scaler line start / data / write strobe
//   STA_UFL_OUT            sticky underflow, cleared in IDLE with run low
//   STA_LINES_OUT          completed-line counter, wraps at 16 bits
module prt_scaler_hbs_ctl
   import prt_scaler_hbs_ctl_pkg::*;
#(
   parameter int unsigned P_PPC = 4,
   parameter int unsigned P_BPC = 8,
   parameter int unsigned P_HW  = 16
) (
   input  logic                     CLK_IN,
   input  logic                     RST_IN,
   input  logic                     CTL_RUN_IN,
   input  logic [P_HW-1:0]          CFG_HWORDS_IN,
   input  logic                     FIFO_EP_IN,
   output logic                     FIFO_RD_OUT,
   input  logic [P_PPC*P_BPC-1:0]   FIFO_DAT_IN,
   output logic                     HBS_HS_OUT,
   output logic [P_PPC*P_BPC-1:0]   HBS_DAT_OUT,
   output logic                     HBS_WR_OUT,
   output logic                     STA_UFL_OUT,
   output logic [LINES_W-1:0]       STA_LINES_OUT
);

   localparam int unsigned DW     = P_PPC * P_BPC;
   localparam int unsigned LEND_W = (LEND_CYCLES > 1) ? $clog2(LEND_CYCLES) : 1;

   hbs_state_e          state_q, state_d;
   logic [P_HW-1:0]     limit_q, limit_d;
   logic [P_HW-1:0]     wcnt_q, wcnt_d;
   logic [P_HW-1:0]     wcnt_inc;
   logic                phase_q, phase_d;
   logic [LEND_W-1:0]   lend_q, lend_d;
   logic                hs_q, hs_d;
   logic                wr_q, wr_d;
   logic [DW-1:0]       dat_q, dat_d;
   logic                ufl_q, ufl_d;
   logic                ufl_set, ufl_clr;
   logic [LINES_W-1:0]  lines_q, lines_d;
   logic                rd_c;

   // State and status registers
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         state_q <= ST_IDLE;
         limit_q <= '0;
         wcnt_q  <= '0;
         phase_q <= 1'b0;
         lend_q  <= '0;
         hs_q    <= 1'b0;
         wr_q    <= 1'b0;
         dat_q   <= '0;
         ufl_q   <= 1'b0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         limit_q <= limit_d;
         wcnt_q  <= wcnt_d;
         phase_q <= phase_d;
         lend_q  <= lend_d;
         hs_q    <= hs_d;
         wr_q    <= wr_d;
         dat_q   <= dat_d;
         ufl_q   <= ufl_d;
         lines_q <= lines_d;
      end
   end

   // Next-state and datapath decode
   always_comb begin
      state_d  = state_q;
      limit_d  = limit_q;
      wcnt_d   = wcnt_q;
      phase_d  = phase_q;
      lend_d   = lend_q;
      lines_d  = lines_q;
      ufl_set  = 1'b0;
      ufl_clr  = 1'b0;
      rd_c     = 1'b0;
      wcnt_inc = P_HW'(wcnt_q + P_HW'(1));

      case (state_q)
         ST_IDLE: begin
            ufl_clr = !CTL_RUN_IN;
            if (CTL_RUN_IN && (CFG_HWORDS_IN != '0)) begin
               limit_d = CFG_HWORDS_IN;
               state_d = ST_LSTART;
            end
         end
         ST_LSTART: begin
            wcnt_d  = '0;
            phase_d = 1'b0;
            state_d = ST_READ;
         end
         ST_READ: begin
            // Phase 1 is the mandatory gap after every read
            if (phase_q) begin
               phase_d = 1'b0;
            end else if (FIFO_EP_IN) begin
               ufl_set = 1'b1;
            end else begin
               rd_c    = 1'b1;
               phase_d = 1'b1;
               wcnt_d  = wcnt_inc;
               if (wcnt_inc == limit_q) begin
                  lend_d  = '0;
                  state_d = ST_LEND;
               end
            end
         end
         ST_LEND: begin
            if (lend_q == LEND_W'(LEND_CYCLES - 1)) begin
               lend_d  = '0;
               lines_d = LINES_W'(lines_q + LINES_W'(1));
               // Back-to-back lines re-sample the word count here
               if (CTL_RUN_IN && (CFG_HWORDS_IN != '0)) begin
                  limit_d = CFG_HWORDS_IN;
                  state_d = ST_LSTART;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               lend_d = LEND_W'(lend_q + LEND_W'(1));
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Set has priority over clear
      ufl_d = (ufl_q && !ufl_clr) || ufl_set;
      hs_d  = (state_d == ST_LSTART);
      wr_d  = rd_c;
      // FIFO word is valid in the cycle after the read strobe
      dat_d = wr_q ? FIFO_DAT_IN : dat_q;
   end

   assign FIFO_RD_OUT   = rd_c;
   assign HBS_HS_OUT    = hs_q;
   assign HBS_WR_OUT    = wr_q;
   assign HBS_DAT_OUT   = dat_q;
   assign STA_UFL_OUT   = ufl_q;
   assign STA_LINES_OUT = lines_q;

endmodule

// File: tb/tb_prt_scaler_hbs_ctl.sv
// Self-checking bench for prt_scaler_hbs_ctl: directed line scenarios plus
// randomized FIFO-empty patterns, checked by a line-level read-schedule model.
module tb_prt_scaler_hbs_ctl;

   localparam int unsigned PPC  = 4;
   localparam int unsigned BPC  = 8;
   localparam int unsigned HW   = 16;
   localparam int unsigned DW   = PPC * BPC;
   localparam int          TMAX = 4096;

   logic            clk;
   logic            rst_n;
   logic            run;
   logic [HW-1:0]   cfg;
   logic            ep;
   logic            rd;
   logic [DW-1:0]   fdat;
   logic            hs;
   logic [DW-1:0]   dat;
   logic            wr;
   logic            ufl;
   logic [15:0]     lines;

   prt_scaler_hbs_ctl #(.P_PPC(PPC), .P_BPC(BPC), .P_HW(HW)) dut (
      .CLK_IN        (clk),
      .RST_IN        (rst_n),
      .CTL_RUN_IN    (run),
      .CFG_HWORDS_IN (cfg),
      .FIFO_EP_IN    (ep),
      .FIFO_RD_OUT   (rd),
      .FIFO_DAT_IN   (fdat),
      .HBS_HS_OUT    (hs),
      .HBS_DAT_OUT   (dat),
      .HBS_WR_OUT    (wr),
      .STA_UFL_OUT   (ufl),
      .STA_LINES_OUT (lines)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-cycle trace of inputs driven and outputs observed
   logic          tr_rd    [TMAX];
   logic          tr_wr    [TMAX];
   logic          tr_hs    [TMAX];
   logic          tr_ep    [TMAX];
   logic          tr_ufl   [TMAX];
   logic [DW-1:0] tr_fdat  [TMAX];
   logic [DW-1:0] tr_dat   [TMAX];
   logic [15:0]   tr_lines [TMAX];

   int            cyc;
   int            checks;
   int            failures;
   int            starve;
   bit            ep_rand;
   logic [15:0]   exp_lines;
   logic          exp_ufl;
   logic [DW-1:0] fq[$];

   task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   // One clock: FIFO model presents the popped word the cycle after a read
   task automatic tick();
      logic rd_prev;
      rd_prev = rd;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= TMAX) begin
         $display("FAIL trace_overflow cyc=%0d limit=%0d", cyc, TMAX);
         $fatal(1, "trace overflow");
      end
      if (rd_prev === 1'b1) fdat = fq.pop_front();
      else                  fdat = DW'($urandom);
      while (fq.size() < 4) fq.push_back(DW'($urandom));
      if (starve > 0) begin
         ep = 1'b1;
         starve--;
      end else if (ep_rand) begin
         ep = ($urandom_range(0, 2) == 0);
      end else begin
         ep = 1'b0;
      end
      #1;
      tr_rd[cyc]    = rd;
      tr_wr[cyc]    = wr;
      tr_hs[cyc]    = hs;
      tr_ep[cyc]    = ep;
      tr_ufl[cyc]   = ufl;
      tr_fdat[cyc]  = fdat;
      tr_dat[cyc]   = dat;
      tr_lines[cyc] = lines;
   endtask

   task automatic wait_hs(output int h);
      h = -1;
      for (int i = 0; i < 20 && h < 0; i++) begin
         tick();
         if (tr_hs[cyc] === 1'b1) h = cyc;
      end
      ck("hs_seen", 64'(h >= 0), 64'(1));
      if (h < 0) h = cyc;
   endtask

   // Line model: reads at the earliest non-empty cycle, at least two apart,
   // starting the cycle after HS; drain of two cycles, then count and next HS.
   task automatic check_line(input int h, input int n, input logic hs_next,
                             output int first, output int last);
      int  t;
      int  pos[$];
      bit  stalled;
      int  nrd;
      int  nwr;
      t = h + 1;
      stalled = 0;
      last = h;
      first = h + 1;
      for (int k = 0; k < n; k++) begin
         while (t <= cyc && tr_ep[t] === 1'b1) begin
            stalled = 1;
            t++;
         end
         pos.push_back(t);
         last = t;
         t += 2;
      end
      if (n > 0) first = pos[0];
      if (last + 3 > cyc) begin
         ck("line_trace_short", 64'(cyc), 64'(last + 3));
         return;
      end
      ck("line_hs_start", 64'(tr_hs[h]), 64'(1));
      ck("line_hs_single", 64'(tr_hs[h + 1]), 64'(0));
      foreach (pos[i]) begin
         ck($sformatf("line_rd%0d", i), 64'(tr_rd[pos[i]]), 64'(1));
         ck($sformatf("line_wr%0d", i), 64'(tr_wr[pos[i] + 1]), 64'(1));
         ck($sformatf("line_dat%0d", i), 64'(tr_dat[pos[i] + 2]), 64'(tr_fdat[pos[i] + 1]));
      end
      nrd = 0;
      nwr = 0;
      for (int c = h; c <= last + 3; c++) begin
         nrd += (tr_rd[c] === 1'b1) ? 1 : 0;
         nwr += (tr_wr[c] === 1'b1) ? 1 : 0;
      end
      ck("line_rd_count", 64'(nrd), 64'(n));
      ck("line_wr_count", 64'(nwr), 64'(n));
      ck("line_cnt_before", 64'(tr_lines[last + 2]), 64'(exp_lines));
      exp_lines = 16'(exp_lines + 16'd1);
      ck("line_cnt_after", 64'(tr_lines[last + 3]), 64'(exp_lines));
      exp_ufl = exp_ufl | stalled;
      ck("line_ufl", 64'(tr_ufl[last + 3]), 64'(exp_ufl));
      ck("line_next_hs", 64'(tr_hs[last + 3]), 64'(hs_next));
   endtask

   task automatic run_line(input int h, input int n, input int starve_at, input int cfg8_at,
                           input int drop_at, input logic hs_next,
                           output int first, output int last);
      int rds;
      int budget;
      rds = 0;
      budget = 0;
      while (rds < n && budget < 400) begin
         tick();
         budget++;
         if (tr_rd[cyc] === 1'b1) begin
            rds++;
            if (rds == starve_at) starve = 3;
            if (rds == cfg8_at)   cfg = HW'(8);
            if (rds == drop_at)   run = 1'b0;
         end
      end
      ck("line_reads_seen", 64'(rds), 64'(n));
      repeat (3) tick();
      check_line(h, n, hs_next, first, last);
   endtask

   task automatic idle(input int n);
      int nhs;
      int nrd;
      nhs = 0;
      nrd = 0;
      run = 1'b0;
      repeat (n) begin
         tick();
         nhs += (tr_hs[cyc] === 1'b1) ? 1 : 0;
         nrd += (tr_rd[cyc] === 1'b1) ? 1 : 0;
      end
      exp_ufl = 1'b0;
      ck("idle_no_hs", 64'(nhs), 64'(0));
      ck("idle_no_rd", 64'(nrd), 64'(0));
      ck("idle_ufl_clear", 64'(tr_ufl[cyc]), 64'(0));
      ck("idle_lines", 64'(tr_lines[cyc]), 64'(exp_lines));
   endtask

   initial begin
      int h;
      int c;
      int first;
      int last;
      int rds;
      int n;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      starve    = 0;
      ep_rand   = 0;
      exp_lines = 16'd0;
      exp_ufl   = 1'b0;
      rst_n     = 1'b0;
      run       = 1'b0;
      cfg       = '0;
      ep        = 1'b0;
      fdat      = '0;
      while (fq.size() < 4) fq.push_back(DW'($urandom));

      // Reset state
      tick();
      tick();
      ck("rst_rd", 64'(rd), 64'(0));
      ck("rst_wr", 64'(wr), 64'(0));
      ck("rst_hs", 64'(hs), 64'(0));
      ck("rst_ufl", 64'(ufl), 64'(0));
      ck("rst_lines", 64'(lines), 64'(0));
      ck("rst_dat", 64'(dat), 64'(0));
      rst_n = 1'b1;
      idle(3);

      // Zero word count never starts a line
      cfg = '0;
      run = 1'b1;
      repeat (3) tick();
      ck("zero_cfg_no_hs", 64'(tr_hs[cyc]), 64'(0));
      idle(2);

      // S1: 4 words, FIFO never empty
      cfg = HW'(4);
      c = cyc;
      run = 1'b1;
      wait_hs(h);
      ck("s1_hs_latency", 64'(h), 64'(c + 1));
      run_line(h, 4, 0, 0, 4, 1'b0, first, last);
      ck("s1_first_rd", 64'(first), 64'(h + 1));
      ck("s1_span", 64'(last - first), 64'(6));
      ck("s1_lines", 64'(lines), 64'(1));
      idle(3);

      // S2: FIFO empty for 3 cycles after the 2nd read
      c = cyc;
      run = 1'b1;
      wait_hs(h);
      ck("s2_hs_latency", 64'(h), 64'(c + 1));
      run_line(h, 4, 2, 0, 4, 1'b0, first, last);
      ck("s2_span", 64'(last - first), 64'(8));
      ck("s2_ufl", 64'(tr_ufl[last + 3]), 64'(1));
      idle(3);

      // S3: RUN dropped after the 1st read
      c = cyc;
      run = 1'b1;
      wait_hs(h);
      run_line(h, 4, 0, 0, 1, 1'b0, first, last);
      idle(5);

      // S5: word count changed 4 -> 8 mid-line
      cfg = HW'(4);
      run = 1'b1;
      wait_hs(h);
      run_line(h, 4, 0, 2, 0, 1'b1, first, last);
      h = last + 3;
      run_line(h, 8, 0, 0, 8, 1'b0, first, last);
      ck("s5_span8", 64'(last - first), 64'(14));
      idle(3);

      // S4: reset after the 2nd read
      cfg = HW'(4);
      run = 1'b1;
      wait_hs(h);
      rds = 0;
      for (int i = 0; i < 40 && rds < 2; i++) begin
         tick();
         rds += (tr_rd[cyc] === 1'b1) ? 1 : 0;
      end
      ck("s4_reads_before_rst", 64'(rds), 64'(2));
      rst_n = 1'b0;
      #1;
      ck("s4_rst_rd", 64'(rd), 64'(0));
      ck("s4_rst_wr", 64'(wr), 64'(0));
      ck("s4_rst_hs", 64'(hs), 64'(0));
      ck("s4_rst_ufl", 64'(ufl), 64'(0));
      ck("s4_rst_lines", 64'(lines), 64'(0));
      ck("s4_rst_dat", 64'(dat), 64'(0));
      tick();
      tick();
      ck("s4_rst_hold_rd", 64'(tr_rd[cyc]), 64'(0));
      ck("s4_rst_hold_wr", 64'(tr_wr[cyc]), 64'(0));
      exp_lines = 16'd0;
      exp_ufl   = 1'b0;
      c = cyc;
      rst_n = 1'b1;
      wait_hs(h);
      ck("s4_hs_latency", 64'(h), 64'(c + 1));
      run_line(h, 4, 0, 0, 4, 1'b0, first, last);
      idle(3);

      // Randomized word counts with random FIFO-empty cycles
      ep_rand = 1;
      for (int i = 0; i < 5; i++) begin
         n = int'($urandom_range(1, 6));
         cfg = HW'(n);
         run = 1'b1;
         wait_hs(h);
         run_line(h, n, 0, 0, n, 1'b0, first, last);
         idle(2);
      end
      ep_rand = 0;

      // Line counter wrap from a preloaded value
      force dut.lines_q = 16'd65533;
      tick();
      tick();
      release dut.lines_q;
      exp_lines = 16'd65533;
      tick();
      ck("wrap_preload", 64'(lines), 64'(65533));
      cfg = HW'(1);
      run = 1'b1;
      wait_hs(h);
      run_line(h, 1, 0, 0, 0, 1'b1, first, last);
      h = last + 3;
      run_line(h, 1, 0, 0, 0, 1'b1, first, last);
      ck("wrap_max", 64'(lines), 64'(65535));
      h = last + 3;
      run_line(h, 1, 0, 0, 1, 1'b0, first, last);
      ck("wrap_zero", 64'(lines), 64'(0));
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
